// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST response-analysis stage: FSM states,
// fail counter limit, log entry layout and March element numbering.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int FAIL_CNT_MAX = 255;

  // Log entry is {elem, addr, syndrome}; syndrome sits at bit 0.
  localparam int ELEM_W   = 3;
  localparam int SYND_LSB = 0;

  // March C- element numbering, shared with the controller.
  typedef enum logic [ELEM_W-1:0] {
    M0_W0   = 3'd0,
    M1_R0W1 = 3'd1,
    M2_R1W0 = 3'd2,
    M3_R0W1 = 3'd3,
    M4_R1W0 = 3'd4,
    M5_R0   = 3'd5
  } march_elem_t;

endpackage

// File: rtl/mbist_fail_logger_if.sv
// Compare strobe from the MBIST controller and the fail-log readout port.
interface mbist_fail_logger_if
  import mbist_pkg::*;
#(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
);
  // Handshake: cmp_valid has no ready, every strobe is consumed in the cycle it
  // is high; log_rd_en pops the head entry only when log_empty is low.
  logic                            cmp_valid;
  logic [ELEM_W-1:0]               cmp_elem;
  logic [AWIDTH-1:0]               cmp_addr;
  logic [DWIDTH-1:0]               cmp_exp;
  logic [DWIDTH-1:0]               cmp_act;
  logic                            log_rd_en;
  logic                            log_empty;
  logic [ELEM_W+AWIDTH+DWIDTH-1:0] log_dout;

  modport master (
    output cmp_valid, cmp_elem, cmp_addr, cmp_exp, cmp_act, log_rd_en,
    input  log_empty, log_dout
  );

  modport slave (
    input  cmp_valid, cmp_elem, cmp_addr, cmp_exp, cmp_act, log_rd_en,
    output log_empty, log_dout
  );
endinterface

// File: rtl/mbist_log_fifo.sv
// Synchronous first-word-fall-through FIFO with pointer-plus-count tracking.
// A pop on an empty FIFO is ignored; a push on a full FIFO only lands when a pop frees a slot.
module mbist_log_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic [PW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_nxt;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head register: follow the next stored word, or the incoming word when it becomes the head.
      if (pop_ok) begin
        if (count > (PW+1)'(1)) begin
          dout <= mem[rd_nxt];
        end else if (push_ok) begin
          dout <= din;
        end
      end else if (push_ok && empty) begin
        dout <= din;
      end
    end
  end
endmodule

// File: rtl/mbist_fail_logger.sv
// MBIST response analyser: compares read data against the March pattern,
// tracks fail/count/overflow, logs failing accesses and reports the verdict.
module mbist_fail_logger
  import mbist_pkg::*;
#(
  parameter int AWIDTH    = 4,
  parameter int DWIDTH    = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                test_mode,
  input  logic                bist_done,
  mbist_fail_logger_if.slave  bus,
  output logic                fail,
  output logic [7:0]          fail_count,
  output logic                overflow,
  output logic                session_done,
  output logic                pass,
  output state_t              state
);
  localparam int LOG_W = ELEM_W + AWIDTH + DWIDTH;

  logic              tm_q;
  logic [DWIDTH-1:0] syndrome;
  logic              mism;
  logic              start;
  logic              log_full;
  logic [LOG_W-1:0]  entry;

  assign syndrome = bus.cmp_exp ^ bus.cmp_act;
  assign mism     = (state == ACTIVE) && bus.cmp_valid && (syndrome != '0);
  assign start    = (state == IDLE) && test_mode && !tm_q;
  assign entry    = {bus.cmp_elem, bus.cmp_addr, syndrome};

  mbist_log_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .push  (mism),
    .pop   (bus.log_rd_en),
    .din   (entry),
    .dout  (bus.log_dout),
    .full  (log_full),
    .empty (bus.log_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tm_q         <= 1'b0;
      fail         <= 1'b0;
      fail_count   <= '0;
      overflow     <= 1'b0;
      session_done <= 1'b0;
      pass         <= 1'b0;
    end else begin
      tm_q <= test_mode;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACTIVE;
            fail       <= 1'b0;
            fail_count <= '0;
            overflow   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (mism) begin
            fail <= 1'b1;
            if (fail_count != 8'(FAIL_CNT_MAX)) begin
              fail_count <= fail_count + 1'b1;
            end
            // A pop in the same cycle frees the slot, so nothing is dropped then.
            if (log_full && !bus.log_rd_en) begin
              overflow <= 1'b1;
            end
          end
          if (!test_mode) begin
            state <= IDLE;
          end else if (bist_done) begin
            state        <= DONE;
            session_done <= 1'b1;
            pass         <= !(fail || mism);
          end
        end
        DONE: begin
          if (!test_mode) begin
            state        <= IDLE;
            session_done <= 1'b0;
            pass         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mbist_fail_logger.md
# mbist_fail_logger

Response-analysis stage directly downstream of the MBIST controller. Each cycle it compares memory read data against the expected March pattern, keeps a sticky fail flag and a saturating fail counter, and stores failing accesses (element, address, syndrome) in a small log FIFO. Test software or the bench drains the FIFO after the session. It also produces the session pass/fail verdict.

## Interface
Parameters:
- AWIDTH, 4, memory address width
- DWIDTH, 8, memory data width
- LOG_DEPTH, 4, number of log FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  single clock; all logic rising-edge
- rst  input  1  reset, synchronous and active-high
- test_mode  input  1  session enable from the controller's test_mode input
- bist_done  input  1  one-cycle pulse: March sequence finished
- cmp_valid  input  1  compare strobe for the current read
- cmp_elem  input  3  March element index of the read
- cmp_addr  input  AWIDTH  address of the read
- cmp_exp  input  DWIDTH  expected data
- cmp_act  input  DWIDTH  data read from memory
- fail  output  1  sticky: any mismatch this session
- fail_count  output  8  number of mismatches, saturates at 255
- overflow  output  1  sticky: a mismatch was dropped because the log was full
- session_done  output  1  high in DONE
- pass  output  1  session_done & ~fail
- log_rd_en  input  1  pop request
- log_empty  output  1  log holds no entries
- log_dout  output  3+AWIDTH+DWIDTH  {elem, addr, syndrome} of the head entry; first-word-fall-through

## Operation
- State machine states: IDLE, ACTIVE, DONE. Reset puts the block in IDLE.
- IDLE→ACTIVE: test_mode goes 0→1 (edge detected on a registered copy). Entering ACTIVE clears fail, fail_count, overflow, and the log.
- ACTIVE→DONE: bist_done=1.
- ACTIVE or DONE→IDLE: test_mode=0. Counters, flags, and the log are kept for readout.
- Comparisons happen only in ACTIVE with cmp_valid=1. The syndrome is cmp_exp ^ cmp_act. A mismatch is any syndrome ≠ 0.
- On a mismatch:
  - fail is set.
  - fail_count increments, saturating at 255.
  - The entry is pushed if the log is not full. If the log is full, the entry is dropped and overflow is set.
- cmp_valid in IDLE or DONE is ignored.
- bist_done and a mismatching cmp_valid in the same cycle: the compare is logged, then the block goes to DONE.
- Pops are allowed in any state. log_rd_en while log_empty=1 is ignored.
- Push and pop in the same cycle:
  - Log full: both take effect and no overflow is flagged.
  - Log empty: only the push takes effect.
- A session-start clear in the same cycle as log_rd_en: the clear wins.

## Timing
- Reset values: fail=0, fail_count=0, overflow=0, session_done=0, pass=0, log_empty=1, log_dout=0.
- All outputs are registered.
- fail, fail_count, and overflow update one cycle after the mismatching compare cycle.
- log_empty falls one cycle after the first push. log_dout is valid whenever log_empty=0.
- After a pop, log_dout shows the next entry on the following cycle.
- session_done and pass rise one cycle after bist_done is sampled.
- Clear on session start takes effect one cycle after test_mode is first sampled high. Compares are accepted from the cycle after that.
- A rst assertion mid-session aborts immediately to the reset values. The FIFO pointers and count are reset; the storage contents need not be.

## Structure
- Shared package mbist_pkg holds:
  - the state enum (IDLE, ACTIVE, DONE)
  - FAIL_CNT_MAX=255
  - the log entry field widths/offsets (ELEM_W=3)
  - the March element index encoding shared with the controller
- Sub-module mbist_log_fifo: synchronous FWFT FIFO parameterised by width and depth. It has a pointer-plus-count implementation and full/empty outputs, and it honours the simultaneous push/pop rules above.

## Test plan
- Clean session: test_mode=1, 16 compares with cmp_exp=cmp_act, then bist_done → fail=0, fail_count=0, log_empty=1, pass=1 one cycle after bist_done.
- Single stuck-at fault: cmp_addr=4'h3, elem=2, exp=8'hFF, act=8'hFE → fail=1 next cycle, fail_count=1, log_dout={3'd2,4'h3,8'h01}, pop → log_empty=1.
- Overflow: 6 mismatches with LOG_DEPTH=4 → 4 entries logged in order, overflow=1, fail_count=6. Then a push+pop on a full log → still 4 entries, overflow unchanged.
- Saturation: 300 mismatches → fail_count=255; after bist_done, pass=0.
- Restart and reset: a second test_mode 0→1 clears all flags and the log. rst asserted mid-ACTIVE returns every output to its reset value on the next edge.
- Ignored inputs: mismatching cmp_valid in IDLE and after DONE → no change. bist_done together with a mismatch → the entry is logged and pass=0.
